// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at accept and retired to HI/LO when the busy counter expires.
module ex_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  // Low 64 bits of the product of the extended operands equal the true product.
  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {(sgn ? {32{x[31]}} : 32'd0), x};
    ye = {(sgn ? {32{y[31]}} : 32'd0), y};
    return xe * ye;
  endfunction

  // Sign-magnitude division so 0x80000000 / -1 wraps cleanly; returns {rem, quo}.
  function automatic logic [63:0] div64(input logic [31:0] n, input logic [31:0] d,
                                        input logic sgn);
    logic        neg_n;
    logic        neg_d;
    logic [31:0] n_mag;
    logic [31:0] d_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    neg_n = sgn & n[31];
    neg_d = sgn & d[31];
    n_mag = neg_n ? (32'd0 - n) : n;
    d_mag = neg_d ? (32'd0 - d) : d;
    if (d_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = n_mag / d_mag;
      r_mag = n_mag % d_mag;
    end
    quo = (neg_n ^ neg_d) ? (32'd0 - q_mag) : q_mag;
    rem = neg_n ? (32'd0 - r_mag) : r_mag;
    return {rem, quo};
  endfunction

  op_e              op_s;
  logic             accept_s;
  logic             md_acc_s;
  logic             mthi_s;
  logic             mtlo_s;
  logic             wr_s;
  logic             done_s;
  logic [63:0]      res_s;
  logic [CNT_W-1:0] cnt_load_s;

  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             wr_r;
  logic [63:0]      res_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;

  // Op decode, accept qualification and result computation.
  always_comb begin
    op_s       = op_e'(op);
    accept_s   = start & ~cancel & ~busy_r;
    md_acc_s   = 1'b0;
    mthi_s     = 1'b0;
    mtlo_s     = 1'b0;
    wr_s       = 1'b0;
    res_s      = 64'd0;
    cnt_load_s = {CNT_W{1'b0}};
    case (op_s)
      OP_MULT: begin
        md_acc_s   = accept_s;
        res_s      = mul64(a, b, 1'b1);
        wr_s       = 1'b1;
        cnt_load_s = CNT_W'(MULT_CYCLES);
      end
      OP_MULTU: begin
        md_acc_s   = accept_s;
        res_s      = mul64(a, b, 1'b0);
        wr_s       = 1'b1;
        cnt_load_s = CNT_W'(MULT_CYCLES);
      end
      OP_DIV: begin
        md_acc_s   = accept_s;
        res_s      = div64(a, b, 1'b1);
        wr_s       = (b != 32'd0);
        cnt_load_s = CNT_W'(DIV_CYCLES);
      end
      OP_DIVU: begin
        md_acc_s   = accept_s;
        res_s      = div64(a, b, 1'b0);
        wr_s       = (b != 32'd0);
        cnt_load_s = CNT_W'(DIV_CYCLES);
      end
      OP_MTHI: mthi_s = accept_s;
      OP_MTLO: mtlo_s = accept_s;
      default: md_acc_s = 1'b0;
    endcase
    done_s = (cnt_r == CNT_W'(1));
  end

  // Latency counter and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (md_acc_s) begin
      cnt_r  <= cnt_load_s;
      busy_r <= 1'b1;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r  <= cnt_r - CNT_W'(1);
      busy_r <= ~done_s;
    end else begin
      cnt_r  <= cnt_r;
      busy_r <= 1'b0;
    end
  end

  // Pending result held from accept until retirement; divide-by-zero never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= 64'd0;
      wr_r  <= 1'b0;
    end else if (md_acc_s) begin
      res_r <= res_s;
      wr_r  <= wr_s;
    end else begin
      res_r <= res_r;
      wr_r  <= wr_r;
    end
  end

  // HI register: direct move or retirement of a pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= 32'd0;
    end else if (mthi_s) begin
      hi_r <= a;
    end else if (done_s && wr_r) begin
      hi_r <= res_r[63:32];
    end else begin
      hi_r <= hi_r;
    end
  end

  // LO register: direct move or retirement of a pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r <= 32'd0;
    end else if (mtlo_s) begin
      lo_r <= a;
    end else if (done_s && wr_r) begin
      lo_r <= res_r[31:0];
    end else begin
      lo_r <= lo_r;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed plan vectors plus random ops
// checked against an arithmetic model of the HI/LO results and latencies.
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          chk;
  int          err;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  ex_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int latency(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return 5;
    if (o == 3'd3 || o == 3'd4) return 10;
    return 0;
  endfunction

  // Architectural effect of one accepted op on the model HI/LO.
  task automatic model_exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      p;
    longint      n;
    longint      d;
    logic [63:0] pu;
    case (o)
      3'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        hi_m = 32'(p >>> 32);
        lo_m = 32'(p);
      end
      3'd2: begin
        pu = {32'd0, x} * {32'd0, y};
        hi_m = pu[63:32];
        lo_m = pu[31:0];
      end
      3'd3: if (y != 32'd0) begin
        n = longint'($signed(x));
        d = longint'($signed(y));
        lo_m = 32'(n / d);
        hi_m = 32'(n % d);
      end
      3'd4: if (y != 32'd0) begin
        lo_m = x / y;
        hi_m = x % y;
      end
      3'd5: hi_m = x;
      3'd6: lo_m = x;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, watch busy, then check latency and final HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    old_hi = hi_m;
    old_lo = lo_m;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      chk++;
      if (hi !== old_hi || lo !== old_lo) begin
        err++;
        $display("FAIL %s hold: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, old_hi, old_lo);
      end
      n++;
      tick();
    end
    model_exec(o, x, y);
    chk++;
    if (n !== latency(o)) begin
      err++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, latency(o));
    end
    chk++;
    if (hi !== hi_m) begin
      err++;
      $display("FAIL %s hi: got %h expected %h", name, hi, hi_m);
    end
    chk++;
    if (lo !== lo_m) begin
      err++;
      $display("FAIL %s lo: got %h expected %h", name, lo, lo_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    #1;
    chk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      err++;
      $display("FAIL reset_async: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      err++;
      $display("FAIL reset_release: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
    end
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    chk++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      err++;
      $display("FAIL mult_const: got %h_%h expected ffffffff_fffffffa", hi, lo);
    end
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    chk++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      err++;
      $display("FAIL multu_const: got %h_%h expected 00000002_fffffffa", hi, lo);
    end
    run_op(3'd4, 32'd7, 32'd2, "divu");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      err++;
      $display("FAIL div_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      err++;
      $display("FAIL div_ovf_const: got %h_%h expected 00000000_80000000", hi, lo);
    end
  endtask

  task automatic test_mt_divzero();
    run_op(3'd5, 32'h0000_1234, 32'd0, "mthi");
    run_op(3'd6, 32'h0000_5678, 32'd0, "mtlo");
    run_op(3'd3, 32'h0BAD_F00D, 32'd0, "div_by_zero");
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, "divu_by_zero");
    chk++;
    if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
      err++;
      $display("FAIL divzero_const: got %h_%h expected 00001234_00005678", hi, lo);
    end
  endtask

  task automatic test_cancel();
    start = 1'b1; op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; cancel = 1'b1;
    tick();
    start = 1'b0; op = 3'd0; cancel = 1'b0;
    chk++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL cancel_busy: got %b expected 0", busy);
    end
    repeat (6) tick();
    chk++;
    if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
      err++;
      $display("FAIL cancel_hilo: busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, hi_m, lo_m);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] x;
    logic [31:0] y;
    int n;
    x = $urandom; y = $urandom;
    start = 1'b1; op = 3'd1; a = x; b = y;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      if (n == 0) begin
        start = 1'b1; op = 3'd3; a = $urandom; b = $urandom | 32'd1;
      end else begin
        start = 1'b0; op = 3'd0;
      end
      n++;
      tick();
    end
    start = 1'b0; op = 3'd0;
    model_exec(3'd1, x, y);
    chk++;
    if (n !== 5) begin
      err++;
      $display("FAIL busy_start latency: got %0d expected 5", n);
    end
    chk++;
    if (hi !== hi_m || lo !== lo_m) begin
      err++;
      $display("FAIL busy_start result: got %h_%h expected %h_%h", hi, lo, hi_m, lo_m);
    end
    tick();
    chk++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL busy_start ignored: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(1, 6));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 31);
      if ((o == 3'd3 || o == 3'd4) && $urandom_range(0, 5) == 0) y = 32'd0;
      run_op(o, x, y, "random");
    end
  endtask

  task automatic test_async_reset();
    run_op(3'd5, 32'hCAFE_0001, 32'd0, "pre_reset_mthi");
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    tick();
    start = 1'b0; op = 3'd0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    hi_m = 32'd0; lo_m = 32'd0;
    chk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      err++;
      $display("FAIL midop_reset: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
    end
    #1 rst_n = 1'b1;
    repeat (12) tick();
    chk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      err++;
      $display("FAIL post_reset: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
    end
  endtask

  initial begin
    chk = 0;
    err = 0;
    test_reset();
    test_directed();
    test_mt_divzero();
    test_cancel();
    test_start_while_busy();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
